// File: rtl/sram_ctrl.sv
// sram_ctrl: writes a DEPTH-bit pattern one bit per address into a bit-serial SRAM, reads it back, flags mismatches (read-back gated by READBACK_VERIFY_EN).
// Latency: done 2*DEPTH+1 edges after the accepted start edge (DEPTH+1 without read-back, 1 for a no-op); every output is a register.
// Backpressure: none; start edges arriving while busy are dropped, so one rising edge yields exactly one operation.
module sram_ctrl #(
    parameter int ADDR_W = 2,
    localparam int DEPTH = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [DEPTH-1:0]  pattern,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_din,
    input  logic              mem_dout,
    output logic              busy,
    output logic              done,
    output logic [DEPTH-1:0]  rd_word,
    output logic [DEPTH-1:0]  err_mask,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              start_q;
    logic [DEPTH-1:0]  pat_q, pat_nxt;
    logic              op_q, op_nxt;
    logic [DEPTH-1:0]  rd_nxt, err_nxt;
    logic              error_nxt;
    logic              rw_nxt, din_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              accept;

    assign accept = start & ~start_q & (state == IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pat_nxt   = pat_q;
        op_nxt    = op_q;
        rd_nxt    = rd_word;
        err_nxt   = err_mask;
        error_nxt = error;
        rw_nxt    = 1'b0;
        addr_nxt  = '0;
        din_nxt   = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    pat_nxt   = pattern;
                    op_nxt    = op;
                    rd_nxt    = '0;
                    err_nxt   = '0;
                    error_nxt = 1'b0;
                    cnt_nxt   = '0;
`ifdef READBACK_VERIFY_EN
                    state_nxt = op ? READ : WRITE;
`else
                    state_nxt = op ? DONE : WRITE;
`endif
                end
            end
            WRITE: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
`ifdef READBACK_VERIFY_EN
                    state_nxt = READ;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READ: begin
                rd_nxt[cnt] = mem_dout;
                if (cnt == LAST) begin
                    // Compare uses the word including the bit captured on this very edge.
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                    err_nxt   = op_q ? '0 : (rd_nxt ^ pat_q);
                    error_nxt = |err_nxt;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // SRAM-side outputs are decoded from the upcoming state so they leave a register.
        case (state_nxt)
            WRITE: begin
                rw_nxt   = 1'b1;
                addr_nxt = cnt_nxt;
                din_nxt  = pat_nxt[cnt_nxt];
            end
            READ:    addr_nxt = cnt_nxt;
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            start_q  <= 1'b0;
            pat_q    <= '0;
            op_q     <= 1'b0;
            mem_rw   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_word  <= '0;
            err_mask <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            start_q  <= start;
            pat_q    <= pat_nxt;
            op_q     <= op_nxt;
            mem_rw   <= rw_nxt;
            mem_addr <= addr_nxt;
            mem_din  <= din_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            rd_word  <= rd_nxt;
            err_mask <= err_nxt;
            error    <= error_nxt;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a 4x1 SRAM model (optional stuck-at-0 on address 2).
module tb_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op;
    logic [3:0] pattern;
    logic       mem_rw;
    logic [1:0] mem_addr;
    logic       mem_din;
    logic       mem_dout;
    logic       busy;
    logic       done;
    logic [3:0] rd_word;
    logic [3:0] err_mask;
    logic       error;

    int total = 0;
    int bad   = 0;

    logic [3:0]  mem = 4'b0000;
    logic        stuck = 1'b0;
    int          wr_n = 0;
    logic [11:0] wr_hist = '0;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .pattern(pattern),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .done(done), .rd_word(rd_word), .err_mask(err_mask), .error(error)
    );

    assign mem_dout = (stuck && mem_addr == 2'd2) ? 1'b0 : mem[mem_addr];

    always @(posedge clk) begin
        if (mem_rw === 1'b1) begin
            mem[mem_addr] <= mem_din;
            wr_hist = {wr_hist[8:0], mem_addr, mem_din};
            wr_n++;
        end
    end

    // Launches one operation; lat = edges from the accept edge (inclusive) to first done sample.
    task automatic run_op(input logic op_v, input logic [3:0] pat_v,
                          output int lat, output int ndone, output logic busy1);
        @(negedge clk);
        op = op_v;
        pattern = pat_v;
        start = 1'b1;
        lat = -1;
        ndone = 0;
        busy1 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (k == 2) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        op = 1'b0;
        pattern = 4'b0000;
        #12;
        total++; if (mem_rw !== 1'b0) begin bad++; $display("FAIL reset_mem_rw got=%b want=0", mem_rw); end
        total++; if (mem_addr !== 2'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
        total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, error}); end
        total++; if ({rd_word, err_mask} !== 8'h00) begin bad++; $display("FAIL reset_words got=%h want=00", {rd_word, err_mask}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef READBACK_VERIFY_EN
    task automatic test_write_verify;
        int lat, nd, w0;
        logic b1;
        w0 = wr_n;
        run_op(1'b0, 4'b1010, lat, nd, b1);
        total++; if (wr_n - w0 !== 4) begin bad++; $display("FAIL t2_write_count got=%0d want=4", wr_n - w0); end
        total++; if (wr_hist !== 12'b000_011_100_111) begin bad++; $display("FAIL t2_write_seq got=%b want=000011100111", wr_hist); end
        total++; if (mem !== 4'b1010) begin bad++; $display("FAIL t2_sram got=%b want=1010", mem); end
        total++; if (rd_word !== 4'b1010) begin bad++; $display("FAIL t2_rd_word got=%b want=1010", rd_word); end
        total++; if ({err_mask, error} !== 5'b0) begin bad++; $display("FAIL t2_error got=%b want=00000", {err_mask, error}); end
        total++; if (lat !== 9) begin bad++; $display("FAIL t2_latency got=%0d want=9", lat); end
        total++; if (nd !== 1) begin bad++; $display("FAIL t2_done_pulses got=%0d want=1", nd); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL t2_busy_after_accept got=%b want=1", b1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t2_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_read_dump;
        int lat, nd, w0;
        logic b1;
        w0 = wr_n;
        run_op(1'b1, 4'b0101, lat, nd, b1);
        total++; if (wr_n - w0 !== 0) begin bad++; $display("FAIL t5_writes got=%0d want=0", wr_n - w0); end
        total++; if (rd_word !== 4'b1010) begin bad++; $display("FAIL t5_rd_word got=%b want=1010", rd_word); end
        total++; if ({err_mask, error} !== 5'b0) begin bad++; $display("FAIL t5_error got=%b want=00000", {err_mask, error}); end
        total++; if (lat !== 5) begin bad++; $display("FAIL t5_latency got=%0d want=5", lat); end
    endtask

    task automatic test_stuck_bit;
        int lat, nd;
        logic b1;
        stuck = 1'b1;
        run_op(1'b0, 4'b0110, lat, nd, b1);
        stuck = 1'b0;
        total++; if (rd_word !== 4'b0010) begin bad++; $display("FAIL t3_rd_word got=%b want=0010", rd_word); end
        total++; if (err_mask !== 4'b0100) begin bad++; $display("FAIL t3_err_mask got=%b want=0100", err_mask); end
        repeat (5) @(negedge clk);
        total++; if (error !== 1'b1) begin bad++; $display("FAIL t3_error_sticky got=%b want=1", error); end
    endtask
`else
    task automatic test_no_verify;
        int lat, nd, w0;
        logic b1;
        w0 = wr_n;
        run_op(1'b0, 4'b1111, lat, nd, b1);
        total++; if (wr_n - w0 !== 4) begin bad++; $display("FAIL t6_write_count got=%0d want=4", wr_n - w0); end
        total++; if (wr_hist !== 12'b001_011_101_111) begin bad++; $display("FAIL t6_write_seq got=%b want=001011101111", wr_hist); end
        total++; if (mem !== 4'b1111) begin bad++; $display("FAIL t6_sram got=%b want=1111", mem); end
        total++; if (lat !== 5) begin bad++; $display("FAIL t6_latency got=%0d want=5", lat); end
        total++; if (nd !== 1) begin bad++; $display("FAIL t6_done_pulses got=%0d want=1", nd); end
        total++; if ({rd_word, err_mask, error} !== 9'b0) begin bad++; $display("FAIL t6_results got=%b want=0", {rd_word, err_mask, error}); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL t6_busy_after_accept got=%b want=1", b1); end
        w0 = wr_n;
        run_op(1'b1, 4'b0000, lat, nd, b1);
        total++; if (wr_n - w0 !== 0) begin bad++; $display("FAIL t6_noop_writes got=%0d want=0", wr_n - w0); end
        total++; if (lat !== 1) begin bad++; $display("FAIL t6_noop_latency got=%0d want=1", lat); end
        total++; if (nd !== 1) begin bad++; $display("FAIL t6_noop_done got=%0d want=1", nd); end
    endtask
`endif

    task automatic test_held_start;
        int nd;
        nd = 0;
        @(negedge clk);
        op = 1'b0;
        pattern = 4'b1010;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                total++; if (error !== 1'b0) begin bad++; $display("FAIL t4_error_cleared got=%b want=0", error); end
            end
            if (k == 3) start = 1'b0;
            if (k == 4) start = 1'b1;
            if (done === 1'b1) nd++;
        end
        start = 1'b0;
        total++; if (nd !== 1) begin bad++; $display("FAIL t4_done_pulses got=%0d want=1", nd); end
    endtask

    task automatic test_reset_mid_write;
        int w0;
        @(negedge clk);
        op = 1'b0;
        pattern = 4'b0101;
        start = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (mem_rw !== 1'b1) begin bad++; $display("FAIL t1_in_write got=%b want=1", mem_rw); end
        #2 rst = 1'b1;
        #1;
        w0 = wr_n;
        total++; if ({mem_rw, mem_din, busy, done, error} !== 5'b0) begin bad++; $display("FAIL t1_abort_flags got=%b want=00000", {mem_rw, mem_din, busy, done, error}); end
        total++; if ({mem_addr, rd_word, err_mask} !== 10'b0) begin bad++; $display("FAIL t1_abort_buses got=%b want=0", {mem_addr, rd_word, err_mask}); end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (wr_n !== w0) begin bad++; $display("FAIL t1_no_write_after got=%0d want=%0d", wr_n, w0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t1_idle_after got=%b want=0", busy); end
    endtask

    initial begin
        test_reset;
`ifdef READBACK_VERIFY_EN
        test_write_verify;
        test_read_dump;
        test_stuck_bit;
`else
        test_no_verify;
`endif
        test_held_start;
        test_reset_mid_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
